instr_fetch_stage: RTL and testbench

Stage-3 instruction fetch unit sitting directly upstream of the stage-4 decode/shift/extend logic. Holds the program counter (PC) and instruction register (IR), fetches 16-bit words from word-addressed instruction memory over a req/ack handshake, and drives `IROut` into stage 4. It consumes the stage-4 control outputs `IRWrite`, `PCWrite`, `PCSource` and `PCAdd`, plus `SignExtOut`, to sequence fetches and redirect the PC.

---
 rtl/instr_fetch_stage_pkg.sv | 15 +
 rtl/fetch_pc_unit.sv | 47 ++++
 rtl/instr_fetch_stage.sv | 198 +++++++++++++++++++
 tb/tb_instr_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared types for the instruction fetch stage.
// Holds the fetch FSM states, the instruction word type and the default NOP word.
package instr_fetch_stage_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        PREFETCH = 2'd2
    } state_e;

    localparam word_t NOP_WORD_DEF = 16'h0000;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter register with its next-PC mux.
// A redirect from stage 4 always beats the post-fetch auto-increment.
module fetch_pc_unit
    import instr_fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  pc_write_i,
    input  logic  pc_source_i,
    input  logic  pc_add_i,
    input  logic  inc_i,
    input  word_t sign_ext_i,
    input  word_t jump_target_i,
    output word_t pc_o
);

    word_t pc_q;
    word_t pc_d;

    // Next PC: absolute, relative or sequential redirect, else auto-increment
    always_comb begin
        pc_d = pc_q;
        if (pc_write_i) begin
            if (pc_source_i)
                pc_d = jump_target_i;
            else if (pc_add_i)
                pc_d = pc_q + sign_ext_i;
            else
                pc_d = pc_q + 16'd1;
        end else if (inc_i) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // PC register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: PC/IR holder fetching 16-bit words over a req/ack bus.
// Define FETCH_PREFETCH_EN to add a one-entry tagged prefetch buffer.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter word_t       RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15,
    parameter word_t       NOP_WORD = NOP_WORD_DEF
) (
    input  logic  CLK,
    input  logic  RST_N,
    input  logic  IRWrite,
    input  logic  PCWrite,
    input  logic  PCSource,
    input  logic  PCAdd,
    input  word_t SignExtIn,
    input  word_t JumpTarget,
    output logic  MemReq,
    output word_t MemAddr,
    input  logic  MemAck,
    input  word_t MemRdata,
    output word_t IROut,
    output word_t PCOut,
    output logic  Busy,
    output logic  FetchErr
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e     state_q;
    word_t      ir_q;
    word_t      addr_q;
    logic       req_q;
    logic       busy_q;
    logic       err_q;
    logic       redir_q;
    logic [7:0] cnt_q;
    logic       inc;
    logic       to_hit;
    word_t      pc;

    assign to_hit = (cnt_q == TO_LAST);

`ifdef FETCH_PREFETCH_EN
    word_t buf_tag_q;
    word_t buf_data_q;
    logic  buf_v_q;
    logic  disc_q;
    logic  pend_q;
    logic  buf_hit;
    logic  pf_hit;

    assign buf_hit = IRWrite && buf_v_q && (buf_tag_q == pc);
    assign pf_hit  = IRWrite && !PCWrite && !pend_q && !disc_q
                   && (addr_q == pc);
`endif

    // Auto-increment after a word lands in IR, unless PC was redirected
    always_comb begin
        inc = (state_q == FETCH) && MemAck && !redir_q;
`ifdef FETCH_PREFETCH_EN
        if (state_q == IDLE && buf_hit)
            inc = 1'b1;
        if (state_q == PREFETCH && MemAck && pf_hit)
            inc = 1'b1;
`endif
    end

    fetch_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i         (CLK),
        .rst_ni        (RST_N),
        .pc_write_i    (PCWrite),
        .pc_source_i   (PCSource),
        .pc_add_i      (PCAdd),
        .inc_i         (inc),
        .sign_ext_i    (SignExtIn),
        .jump_target_i (JumpTarget),
        .pc_o          (pc)
    );

    // Fetch FSM with registered bus outputs, IR, wait counter and error flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ir_q    <= '0;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            redir_q <= 1'b0;
            cnt_q   <= '0;
`ifdef FETCH_PREFETCH_EN
            buf_v_q    <= 1'b0;
            buf_tag_q  <= '0;
            buf_data_q <= '0;
            disc_q     <= 1'b0;
            pend_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    redir_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
                    if (buf_hit) begin
                        ir_q    <= buf_data_q;
                        buf_v_q <= 1'b0;
                    end else if (IRWrite) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        addr_q  <= pc;
                    end else if (!buf_v_q && !PCWrite) begin
                        state_q <= PREFETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc;
                        disc_q  <= 1'b0;
                        pend_q  <= 1'b0;
                    end
`else
                    if (IRWrite) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        addr_q  <= pc;
                    end
`endif
                end
                FETCH: begin
                    if (MemAck || to_hit) begin
                        ir_q    <= MemAck ? MemRdata : NOP_WORD;
                        if (!MemAck)
                            err_q <= 1'b1;
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        redir_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (PCWrite)
                            redir_q <= 1'b1;
                    end
                end
`ifdef FETCH_PREFETCH_EN
                PREFETCH: begin
                    if (PCWrite)
                        disc_q <= 1'b1;
                    if (MemAck && pf_hit) begin
                        ir_q    <= MemRdata;
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (MemAck || to_hit) begin
                        cnt_q <= '0;
                        if (pend_q || IRWrite) begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                            addr_q  <= pc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                            if (MemAck && !disc_q && !PCWrite) begin
                                buf_v_q    <= 1'b1;
                                buf_tag_q  <= addr_q;
                                buf_data_q <= MemRdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (pf_hit) begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end else if (IRWrite) begin
                            pend_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
`ifdef FETCH_PREFETCH_EN
            if (PCWrite)
                buf_v_q <= 1'b0;
`endif
        end
    end

    assign MemReq   = req_q;
    assign MemAddr  = addr_q;
    assign IROut    = ir_q;
    assign PCOut    = pc;
    assign Busy     = busy_q;
    assign FetchErr = err_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage (default build).
// Directed sequences, a PC-redirect vector table and a randomized model run.
module tb_instr_fetch_stage;
    import instr_fetch_stage_pkg::*;

    localparam int TO = 15;

    logic  CLK = 1'b0;
    logic  RST_N = 1'b0;
    logic  IRWrite = 1'b0;
    logic  PCWrite = 1'b0;
    logic  PCSource = 1'b0;
    logic  PCAdd = 1'b0;
    logic  MemAck = 1'b0;
    word_t SignExtIn = '0;
    word_t JumpTarget = '0;
    word_t MemRdata = '0;
    word_t MemAddr;
    word_t IROut;
    word_t PCOut;
    logic  MemReq;
    logic  Busy;
    logic  FetchErr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    instr_fetch_stage #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (TO),
        .NOP_WORD (16'h0000)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSource   (PCSource),
        .PCAdd      (PCAdd),
        .SignExtIn  (SignExtIn),
        .JumpTarget (JumpTarget),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemRdata   (MemRdata),
        .IROut      (IROut),
        .PCOut      (PCOut),
        .Busy       (Busy),
        .FetchErr   (FetchErr)
    );

    typedef struct {
        word_t start;
        logic  src;
        logic  add;
        word_t sext;
        word_t jt;
        word_t exp;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        IRWrite = 0; PCWrite = 0; PCSource = 0; PCAdd = 0;
        MemAck = 0; SignExtIn = '0; JumpTarget = '0; MemRdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        RST_N = 0;
        tick();
        RST_N = 1;
    endtask

    task automatic set_pc(input word_t v);
        PCWrite = 1; PCSource = 1; JumpTarget = v;
        tick();
        PCWrite = 0; PCSource = 0;
    endtask

    // randomized-run reference state
    word_t m_pc, m_ir, m_addr, nxt_pc;
    logic  m_err, m_busy, m_redir, done;
    int    m_wait;
    int    busy_cnt;

    initial begin
        vt[0] = '{16'h0010, 1'b0, 1'b1, 16'hFFFC, 16'h0000, 16'h000C};
        vt[1] = '{16'h0010, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h1234};
        vt[2] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vt[3] = '{16'h0005, 1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0008};
        vt[4] = '{16'h8000, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0000};
        vt[5] = '{16'h1234, 1'b1, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF};

        // reset state
        idle_in();
        #12;
        RST_N = 1;
        tick();
        chk("rst_memreq", 16'(MemReq), 16'h0);
        chk("rst_memaddr", MemAddr, 16'h0000);
        chk("rst_ir", IROut, 16'h0000);
        chk("rst_pc", PCOut, 16'h0000);
        chk("rst_busy", 16'(Busy), 16'h0);
        chk("rst_err", 16'(FetchErr), 16'h0);

        // basic fetch, ack three cycles after IRWrite
        IRWrite = 1;
        tick();
        IRWrite = 0;
        chk("f1_memreq", 16'(MemReq), 16'h1);
        busy_cnt = 0;
        for (int i = 0; i < 10 && Busy; i++) begin
            busy_cnt++;
            if (i == 2) begin
                MemAck = 1; MemRdata = 16'h8A35;
            end
            tick();
            MemAck = 0;
        end
        chk("f1_busy_cycles", 16'(busy_cnt), 16'd3);
        chk("f1_ir", IROut, 16'h8A35);
        chk("f1_pc", PCOut, 16'h0001);
        chk("f1_memreq_low", 16'(MemReq), 16'h0);

        // redirect during fetch suppresses the increment
        IRWrite = 1;
        tick();
        IRWrite = 0;
        chk("rd_addr", MemAddr, 16'h0001);
        PCWrite = 1; PCSource = 1; JumpTarget = 16'h0040;
        tick();
        PCWrite = 0; PCSource = 0;
        chk("rd_pc_mid", PCOut, 16'h0040);
        chk("rd_busy_mid", 16'(Busy), 16'h1);
        MemAck = 1; MemRdata = 16'h1357;
        tick();
        MemAck = 0;
        chk("rd_ir", IROut, 16'h1357);
        chk("rd_pc", PCOut, 16'h0040);

        // timeout: no ack ever
        IRWrite = 1;
        tick();
        IRWrite = 0;
        repeat (TO - 1) tick();
        chk("to_busy_before", 16'(Busy), 16'h1);
        tick();
        chk("to_busy", 16'(Busy), 16'h0);
        chk("to_ir", IROut, 16'h0000);
        chk("to_err", 16'(FetchErr), 16'h1);
        chk("to_pc", PCOut, 16'h0040);
        chk("to_memreq", 16'(MemReq), 16'h0);
        IRWrite = 1;
        tick();
        IRWrite = 0;
        MemAck = 1; MemRdata = 16'hABCD;
        tick();
        MemAck = 0;
        chk("to_err_sticky", 16'(FetchErr), 16'h1);
        chk("to_next_ir", IROut, 16'hABCD);
        chk("to_next_pc", PCOut, 16'h0041);

        // PC wrap on fetch at FFFF
        set_pc(16'hFFFF);
        IRWrite = 1;
        tick();
        IRWrite = 0;
        MemAck = 1; MemRdata = 16'h0F0F;
        tick();
        MemAck = 0;
        chk("wrap_pc", PCOut, 16'h0000);
        chk("wrap_ir", IROut, 16'h0F0F);

        // async reset mid-fetch, late ack ignored
        IRWrite = 1;
        tick();
        IRWrite = 0;
        tick();
        #2;
        RST_N = 0;
        #1;
        chk("ar_memreq", 16'(MemReq), 16'h0);
        chk("ar_busy", 16'(Busy), 16'h0);
        chk("ar_ir", IROut, 16'h0000);
        chk("ar_pc", PCOut, 16'h0000);
        chk("ar_err", 16'(FetchErr), 16'h0);
        chk("ar_addr", MemAddr, 16'h0000);
        tick();
        RST_N = 1;
        MemAck = 1; MemRdata = 16'h7777;
        tick();
        MemAck = 0;
        chk("ar_late_ir", IROut, 16'h0000);
        chk("ar_late_busy", 16'(Busy), 16'h0);
        chk("ar_late_pc", PCOut, 16'h0000);

        // PC redirect vector table
        for (int i = 0; i < 6; i++) begin
            set_pc(vt[i].start);
            PCWrite = 1; PCSource = vt[i].src; PCAdd = vt[i].add;
            SignExtIn = vt[i].sext; JumpTarget = vt[i].jt;
            tick();
            idle_in();
            chk($sformatf("vec%0d_pc", i), PCOut, vt[i].exp);
        end

        // randomized run against a transaction-level model
        do_reset();
        m_pc = 16'h0000; m_ir = 16'h0000; m_addr = 16'h0000;
        m_err = 0; m_busy = 0; m_redir = 0; m_wait = 0;
        for (int c = 0; c < 800; c++) begin
            IRWrite    = ($urandom_range(0, 3) == 0);
            PCWrite    = ($urandom_range(0, 7) == 0);
            PCSource   = 1'($urandom);
            PCAdd      = 1'($urandom);
            SignExtIn  = 16'($urandom);
            JumpTarget = 16'($urandom);
            MemAck     = ($urandom_range(0, (c < 400) ? 3 : 19) == 0);
            MemRdata   = 16'($urandom);

            nxt_pc = m_pc;
            done = 0;
            if (m_busy) begin
                if (MemAck) begin
                    m_ir = MemRdata;
                    done = 1;
                    if (!m_redir && !PCWrite)
                        nxt_pc = m_pc + 16'd1;
                end else if (m_wait + 1 == TO) begin
                    m_ir = 16'h0000;
                    m_err = 1;
                    done = 1;
                end else begin
                    m_wait++;
                end
                if (PCWrite && !done)
                    m_redir = 1;
                if (done) begin
                    m_busy = 0;
                    m_redir = 0;
                end
            end else if (IRWrite) begin
                m_busy = 1;
                m_addr = m_pc;
                m_wait = 0;
                m_redir = 0;
            end
            if (PCWrite) begin
                if (PCSource)
                    nxt_pc = JumpTarget;
                else if (PCAdd)
                    nxt_pc = m_pc + SignExtIn;
                else
                    nxt_pc = m_pc + 16'd1;
            end
            m_pc = nxt_pc;

            tick();
            chk("rnd_pc", PCOut, m_pc);
            chk("rnd_ir", IROut, m_ir);
            chk("rnd_memreq", 16'(MemReq), 16'(m_busy));
            chk("rnd_busy", 16'(Busy), 16'(m_busy));
            chk("rnd_err", 16'(FetchErr), 16'(m_err));
            if (m_busy)
                chk("rnd_addr", MemAddr, m_addr);
        end
        idle_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
